// File: rtl/cic_comp_pkg.sv
// cic_comp_pkg: shared definitions for the CIC compensation FIR.
//   state_e    : FSM state encoding (IDLE / MAC / OUT)
//   COEF       : default 15-tap symmetric Q1.15 compensation set for an N=3 CIC
//   acc_width(): accumulator width for a given input / coefficient width and tap count
package cic_comp_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MAC  = 2'd1,
    ST_OUT  = 2'd2
  } state_e;

  localparam int unsigned COEF_TAPS = 15;
  localparam int unsigned COEF_BITS = 16;

  // Symmetric around index 7; the folded build relies on COEF[k] == COEF[TAPS-1-k].
  localparam logic signed [COEF_BITS-1:0] COEF [COEF_TAPS] = '{
    -16'sd71,   16'sd153,  -16'sd301,   16'sd605,  -16'sd1203,  16'sd2507,
    -16'sd6001, 16'sd29999,
    -16'sd6001, 16'sd2507, -16'sd1203,  16'sd605,  -16'sd301,   16'sd153,
    -16'sd71
  };

  function automatic int unsigned acc_width(input int unsigned bin,
                                            input int unsigned coef_w,
                                            input int unsigned taps);
    return bin + coef_w + $clog2(taps) + 1;
  endfunction

endpackage

// File: rtl/cic_comp_mac.sv
// cic_comp_mac: multiply-accumulate datapath for cic_comp_fir.
// Optional feature macro: CIC_COMP_SYM_EN (adds a pre-adder so one multiply
// serves a mirrored tap pair).
// Ports:
//   clk, rst_n      : clock, asynchronous active-low reset
//   clr_i           : clear accumulator (takes priority over en_i)
//   en_i            : accumulate coef_i * sample this cycle
//   xb_i, fold_i    : (CIC_COMP_SYM_EN only) mirrored sample and pre-add enable
//   xa_i            : primary sample
//   coef_i          : signed coefficient
//   acc_o           : signed accumulator
module cic_comp_mac
  import cic_comp_pkg::*;
#(
  parameter int unsigned BIN    = 24,
  parameter int unsigned COEF_W = 16,
  parameter int unsigned ACC_W  = 45
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     clr_i,
  input  logic                     en_i,
`ifdef CIC_COMP_SYM_EN
  input  logic signed [BIN-1:0]    xb_i,
  input  logic                     fold_i,
`endif
  input  logic signed [BIN-1:0]    xa_i,
  input  logic signed [COEF_W-1:0] coef_i,
  output logic signed [ACC_W-1:0]  acc_o
);

`ifdef CIC_COMP_SYM_EN
  localparam int unsigned PRE_W = BIN + 1;
`else
  localparam int unsigned PRE_W = BIN;
`endif
  localparam int unsigned PW = PRE_W + COEF_W;

  logic signed [PRE_W-1:0] pre;
  logic signed [PW-1:0]    prod;
  logic signed [ACC_W-1:0] acc_q;

  always_comb begin
`ifdef CIC_COMP_SYM_EN
    pre = fold_i ? (PRE_W'(xa_i) + PRE_W'(xb_i)) : PRE_W'(xa_i);
`else
    pre = xa_i;
`endif
    prod = PW'(pre) * PW'(coef_i);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q <= '0;
    end else if (clr_i) begin
      acc_q <= '0;
    end else if (en_i) begin
      acc_q <= acc_q + ACC_W'(prod);
    end
  end

  assign acc_o = acc_q;

endmodule

// File: rtl/cic_comp_fir.sv
// cic_comp_fir: serial-MAC CIC droop compensation FIR with round-half-up and
// saturation to BOUT bits. One sample is accepted per K+2 clocks at most.
// Optional feature macro: CIC_COMP_SYM_EN (symmetric fold, K=(TAPS+1)/2;
// otherwise direct form, K=TAPS). dout is bit-identical in both builds.
// Ports:
//   clk, rst_n  : clock, asynchronous active-low reset
//   din         : signed input sample (BIN bits), qualified by din_valid
//   din_ready   : advisory, high while idle
//   dout        : signed filtered sample (BOUT bits)
//   dout_valid  : one-cycle pulse with dout
//   dout_sat    : dout was clipped (with dout_valid)
//   ovf         : sticky, a sample arrived while busy and was dropped
module cic_comp_fir
  import cic_comp_pkg::*;
#(
  parameter int unsigned BIN    = 24,
  parameter int unsigned COEF_W = 16,
  parameter int unsigned TAPS   = 15,
  parameter int unsigned SHIFT  = 15,
  parameter int unsigned BOUT   = 18
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic signed [BIN-1:0]  din,
  input  logic                   din_valid,
  output logic                   din_ready,
  output logic signed [BOUT-1:0] dout,
  output logic                   dout_valid,
  output logic                   dout_sat,
  output logic                   ovf
);

  localparam int unsigned PTR_W = $clog2(TAPS);
  localparam int unsigned ACC_W = acc_width(BIN, COEF_W, TAPS);
`ifdef CIC_COMP_SYM_EN
  localparam int unsigned K = (TAPS + 1) / 2;
`else
  localparam int unsigned K = TAPS;
`endif
  localparam logic [PTR_W-1:0] K_LAST = PTR_W'(K - 1);
  localparam logic [PTR_W-1:0] T_LAST = PTR_W'(TAPS - 1);
  localparam logic [PTR_W-1:0] T_CNT  = PTR_W'(TAPS);

  localparam logic signed [ACC_W-1:0] RND_HALF = ACC_W'(1) << (SHIFT - 1);
  localparam logic signed [ACC_W-1:0] OUT_MAX  = ACC_W'((64'sd1 <<< (BOUT - 1)) - 64'sd1);
  localparam logic signed [ACC_W-1:0] OUT_MIN  = -OUT_MAX - ACC_W'(1);

  state_e                  state_q, state_d;
  logic [PTR_W-1:0]        wptr_q, wptr_d;
  logic [PTR_W-1:0]        k_q, k_d;
  logic signed [BIN-1:0]   smp_q [TAPS];
  logic                    wr_en, mac_clr, mac_en;
  logic signed [ACC_W-1:0] acc;
  logic signed [ACC_W-1:0] rnd;
  logic                    clip_hi, clip_lo;
  logic signed [BOUT-1:0]  dout_q, dout_d;
  logic                    valid_q, valid_d, sat_q, sat_d, ovf_q, ovf_d;
  logic [PTR_W-1:0]        ra_idx;

  // (a - b) mod TAPS for a, b in [0, TAPS-1].
  function automatic logic [PTR_W-1:0] ring_sub(input logic [PTR_W-1:0] a,
                                                input logic [PTR_W-1:0] b);
    if (a >= b) return a - b;
    return a + T_CNT - b;
  endfunction

  assign ra_idx = ring_sub(wptr_q, k_q);

`ifdef CIC_COMP_SYM_EN
  logic [PTR_W-1:0] rb_idx;
  logic             fold;
  assign rb_idx = ring_sub(wptr_q, T_LAST - k_q);
  // Last MAC step is the centre tap, which has no mirror partner.
  assign fold   = (k_q != K_LAST);
`endif

  cic_comp_mac #(
    .BIN    (BIN),
    .COEF_W (COEF_W),
    .ACC_W  (ACC_W)
  ) u_mac (
    .clk    (clk),
    .rst_n  (rst_n),
    .clr_i  (mac_clr),
    .en_i   (mac_en),
`ifdef CIC_COMP_SYM_EN
    .xb_i   (smp_q[rb_idx]),
    .fold_i (fold),
`endif
    .xa_i   (smp_q[ra_idx]),
    .coef_i (COEF[k_q]),
    .acc_o  (acc)
  );

  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    wptr_d  = wptr_q;
    wr_en   = 1'b0;
    mac_clr = 1'b0;
    mac_en  = 1'b0;
    dout_d  = dout_q;
    valid_d = 1'b0;
    sat_d   = 1'b0;
    ovf_d   = ovf_q | (din_valid & (state_q != ST_IDLE));
    rnd     = (acc + RND_HALF) >>> SHIFT;
    clip_hi = (rnd > OUT_MAX);
    clip_lo = (rnd < OUT_MIN);
    unique case (state_q)
      ST_IDLE: begin
        if (din_valid) begin
          wr_en   = 1'b1;
          mac_clr = 1'b1;
          k_d     = '0;
          state_d = ST_MAC;
        end
      end
      ST_MAC: begin
        mac_en = 1'b1;
        if (k_q == K_LAST) state_d = ST_OUT;
        else               k_d     = k_q + 1'b1;
      end
      ST_OUT: begin
        dout_d  = clip_hi ? BOUT'(OUT_MAX) : (clip_lo ? BOUT'(OUT_MIN) : BOUT'(rnd));
        valid_d = 1'b1;
        sat_d   = clip_hi | clip_lo;
        wptr_d  = (wptr_q == T_LAST) ? '0 : wptr_q + 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < TAPS; i++) smp_q[i] <= '0;
    end else if (wr_en) begin
      smp_q[wptr_q] <= din;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      wptr_q  <= '0;
      k_q     <= '0;
      dout_q  <= '0;
      valid_q <= 1'b0;
      sat_q   <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      wptr_q  <= wptr_d;
      k_q     <= k_d;
      dout_q  <= dout_d;
      valid_q <= valid_d;
      sat_q   <= sat_d;
      ovf_q   <= ovf_d;
    end
  end

  assign din_ready  = (state_q == ST_IDLE);
  assign dout       = dout_q;
  assign dout_valid = valid_q;
  assign dout_sat   = sat_q;
  assign ovf        = ovf_q;

endmodule
